// File: rtl/sd_dat_block_reader.sv
// SD 4-bit DAT single-block receiver: clocks the card, deserialises one block into a word FIFO, checks per-line CRC16/end bit.
// Avalon-MM slave with one-cycle registered reads; the FIFO holds a full block, so there is no data backpressure.
module sd_dat_block_reader #(
    parameter int CLK_DIV     = 2,
    parameter int BLOCK_BYTES = 512,
    parameter int TIMEOUT     = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        sd_clk,
    input  logic [3:0]  sd_dat_in
);
    localparam int DEPTH = BLOCK_BYTES / 4;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NIBS  = 2 * BLOCK_BYTES;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int NW    = $clog2(NIBS + 1);
    localparam int CW    = (TW > NW) ? TW : NW;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW    = $clog2(BLOCK_BYTES + 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_CRC, S_END, S_DONE} state_t;

    state_t            state_q;
    logic [DW-1:0]     div_q;
    logic              sd_clk_q;
    logic [CW-1:0]     cnt_q;
    logic [3:0][15:0]  crc_q;
    logic [3:0][15:0]  crc_d;
    logic [3:0]        nib_q;
    logic [31:0]       word_q;
    logic [BW-1:0]     bytes_q;
    logic              done_q, crc_err_q, timeout_q, err_pend_q;

    logic [31:0]       mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;

    logic wr_ctrl, start_req, clear_req, do_abort, strobe;
    logic fifo_clr, fifo_empty, push, pop;
    logic [31:0] push_dat;
    logic unused_wdata;

    assign wr_ctrl    = chipselect & ~write_n & (address == 2'd0);
    assign start_req  = wr_ctrl & writedata[0] & ~writedata[1] & (state_q == S_IDLE);
    assign clear_req  = wr_ctrl & writedata[2];
    assign do_abort   = wr_ctrl & writedata[1] & (state_q != S_IDLE);
    // Strobe is the edge on which sd_clk would rise; the card's data is taken straight from the pad on it.
    assign strobe     = (state_q != S_IDLE) & (div_q == DW'(CLK_DIV - 1)) & ~sd_clk_q;
    assign fifo_clr   = start_req | do_abort;
    assign fifo_empty = (count_q == '0);
    assign push       = strobe & (state_q == S_DATA) & (cnt_q[2:0] == 3'b111);
    assign push_dat   = {nib_q, sd_dat_in, word_q[31:8]};
    assign pop        = chipselect & read & (address == 2'd1) & ~fifo_empty;
    assign sd_clk     = sd_clk_q;
    assign unused_wdata = ^writedata[31:3];

    always_comb begin
        crc_d = crc_q;
        for (int n = 0; n < 4; n++) begin
            crc_d[n] = {crc_q[n][14:0], 1'b0} ^ ((crc_q[n][15] ^ sd_dat_in[n]) ? 16'h1021 : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            sd_clk_q   <= 1'b0;
            cnt_q      <= '0;
            crc_q      <= '0;
            nib_q      <= '0;
            word_q     <= '0;
            bytes_q    <= '0;
            done_q     <= 1'b0;
            crc_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            err_pend_q <= 1'b0;
        end else begin
            if (clear_req) begin
                done_q    <= 1'b0;
                crc_err_q <= 1'b0;
                timeout_q <= 1'b0;
            end
            if (start_req) begin
                state_q   <= S_WAIT;
                div_q     <= '0;
                sd_clk_q  <= 1'b0;
                cnt_q     <= '0;
                bytes_q   <= BW'(BLOCK_BYTES);
                done_q    <= 1'b0;
                crc_err_q <= 1'b0;
                timeout_q <= 1'b0;
            end else if (do_abort) begin
                state_q  <= S_IDLE;
                div_q    <= '0;
                sd_clk_q <= 1'b0;
            end else if (state_q != S_IDLE) begin
                if (div_q == DW'(CLK_DIV - 1)) begin
                    div_q    <= '0;
                    sd_clk_q <= ~sd_clk_q;
                end else begin
                    div_q <= div_q + 1'b1;
                end
                if (state_q == S_DONE) begin
                    state_q   <= S_IDLE;
                    done_q    <= 1'b1;
                    crc_err_q <= err_pend_q;
                    sd_clk_q  <= 1'b0;
                    div_q     <= '0;
                end else if (strobe) begin
                    case (state_q)
                        S_WAIT: begin
                            if (sd_dat_in == 4'h0) begin
                                state_q <= S_DATA;
                                cnt_q   <= '0;
                                crc_q   <= '0;
                            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                                state_q   <= S_IDLE;
                                timeout_q <= 1'b1;
                                sd_clk_q  <= 1'b0;
                                div_q     <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        S_DATA: begin
                            crc_q <= crc_d;
                            if (!cnt_q[0]) begin
                                nib_q <= sd_dat_in;
                            end else begin
                                word_q  <= push_dat;
                                bytes_q <= bytes_q - 1'b1;
                            end
                            if (cnt_q == CW'(NIBS - 1)) begin
                                state_q <= S_CRC;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        S_CRC: begin
                            // Shifting the received CRC through the generator leaves a zero residue when it matches.
                            crc_q <= crc_d;
                            if (cnt_q == CW'(15)) begin
                                state_q <= S_END;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        S_END: begin
                            err_pend_q <= (crc_q != '0) || (sd_dat_in != 4'hF);
                            state_q    <= S_DONE;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (fifo_clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_dat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= {27'd0, ~fifo_empty, timeout_q, crc_err_q, done_q, state_q != S_IDLE};
                2'd1:    readdata <= fifo_empty ? 32'd0 : mem[rd_ptr_q];
                2'd2:    readdata <= 32'(bytes_q);
                default: readdata <= 32'd0;
            endcase
        end
    end
endmodule
